// File: rtl/approx_adder_pkg.sv
// Shared definitions for the approximate adder pipeline.
//   KW           : width of the truncated-LSB count for the default configuration
//   s1_payload_t : stage-1 payload (operands, effective k, low-part sum) laid
//                  out for the default configuration (WIDTH=8, MAX_K=4)
//   clamp_k      : limits a requested truncation count to MAX_K
package approx_adder_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_MAX_K = 4;
  localparam int KW        = $clog2(DEF_MAX_K + 1);

  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [KW-1:0]        keff;
    logic [DEF_MAX_K:0]   lo;
  } s1_payload_t;

  // Requests above max_k are legal and simply saturate.
  function automatic int clamp_k(input int k, input int max_k);
    return (k > max_k) ? max_k : k;
  endfunction

endpackage

// File: rtl/approx_adder_pipe_err_stats.sv
// Running error statistics for the approximate adder.
//   clk, rst_n  : clock, asynchronous active-low reset
//   hs          : output handshake strobe (one result accepted this cycle)
//   err         : error of the result being accepted
//   clear_stats : synchronous clear, wins over a simultaneous update
//   err_count   : number of accepted results with err != 0 (saturating)
//   err_max     : largest err seen
//   err_acc     : sum of err over accepted results (saturating)
module approx_err_stats #(
  parameter int ERR_W = 5,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hs,
  input  logic [ERR_W-1:0] err,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] err_count,
  output logic [ERR_W-1:0] err_max,
  output logic [ACC_W-1:0] err_acc
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [ERR_W-1:0] max_q, max_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum;

  always_comb begin
    count_d = count_q;
    max_d   = max_q;
    acc_d   = acc_q;
    // One extra bit catches the overflow that triggers saturation.
    acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(err);
    if (clear_stats) begin
      count_d = '0;
      max_d   = '0;
      acc_d   = '0;
    end else if (hs) begin
      if ((err != '0) && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
      if (err > max_q) begin
        max_d = err;
      end
      acc_d = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      max_q   <= '0;
      acc_q   <= '0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      acc_q   <= acc_d;
    end
  end

  assign err_count = count_q;
  assign err_max   = max_q;
  assign err_acc   = acc_q;

endmodule

// File: rtl/approx_adder_pipe.sv
// Two-stage pipelined truncated (approximate) adder with in-line error stats.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : input handshake; in_a, in_b operands, in_k truncation
//   out_valid/out_ready   : output handshake
//   out_sum               : approximate sum, low keff bits zero
//   out_exact             : exact a+b
//   out_err               : out_exact - out_sum
//   clear_stats           : synchronous statistics clear
//   err_count/max/acc     : running error statistics
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the sender holds valid and data stable until then. in_ready depends
// combinationally on out_ready so a full pipeline streams without bubbles.
module approx_adder_pipe
  import approx_adder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_K    = 4,
  parameter int CARRY_EN = 0,
  parameter int CNT_W    = 16,
  parameter int ACC_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [$clog2(MAX_K+1)-1:0] in_k,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH:0]             out_sum,
  output logic [WIDTH:0]             out_exact,
  output logic [MAX_K:0]             out_err,
  input  logic                       clear_stats,
  output logic [CNT_W-1:0]           err_count,
  output logic [MAX_K:0]             err_max,
  output logic [ACC_W-1:0]           err_acc
);

  localparam int KEFF_W = $clog2(MAX_K + 1);

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [KEFF_W-1:0] keff;
    logic [MAX_K:0]    lo;
  } s1_t;

  // in_ready is held low until the first edge after reset release.
  logic rdy_en_q, rdy_en_d;

  logic s1_valid_q, s1_valid_d;
  s1_t  s1_q, s1_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   out_sum_q, out_sum_d;
  logic [WIDTH:0]   out_exact_q, out_exact_d;
  logic [MAX_K:0]   out_err_q, out_err_d;

  logic s2_ready;
  logic s1_advance;
  logic in_accept;
  logic out_accept;

  logic [KEFF_W-1:0] in_keff;
  logic [MAX_K:0]    in_mask;
  logic [MAX_K:0]    in_lo;

  logic [MAX_K:0]    s1_mask;
  logic              s1_carry;
  logic [WIDTH:0]    s1_hi;

  assign s2_ready   = !out_valid_q || out_ready;
  assign s1_advance = s1_valid_q && s2_ready;
  assign in_ready   = rdy_en_q && (!s1_valid_q || s1_advance);
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid_q && out_ready;

  // Stage 1: clamp k and add the truncated low parts. Only the low MAX_K
  // operand bits can ever fall under the mask, so the low adder is MAX_K+1 wide.
  always_comb begin
    rdy_en_d   = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    in_keff    = KEFF_W'(clamp_k(int'(in_k), MAX_K));
    in_mask    = ((MAX_K + 1)'(1) << in_keff) - (MAX_K + 1)'(1);
    in_lo      = ({1'b0, in_a[MAX_K-1:0]} & in_mask)
               + ({1'b0, in_b[MAX_K-1:0]} & in_mask);
    if (in_accept) begin
      s1_valid_d = 1'b1;
      s1_d.a     = in_a;
      s1_d.b     = in_b;
      s1_d.keff  = in_keff;
      s1_d.lo    = in_lo;
    end else if (s1_advance) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2: upper-part add, reassembly and error. With the carry forwarded
  // the error is only the bits below keff; without it the whole low sum is lost.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_exact_d = out_exact_q;
    out_err_d   = out_err_q;
    s1_mask     = ((MAX_K + 1)'(1) << s1_q.keff) - (MAX_K + 1)'(1);
    s1_carry    = (CARRY_EN != 0) && ((s1_q.lo & ((MAX_K + 1)'(1) << s1_q.keff)) != '0);
    s1_hi       = (WIDTH + 1)'(s1_q.a >> s1_q.keff)
                + (WIDTH + 1)'(s1_q.b >> s1_q.keff)
                + (WIDTH + 1)'(s1_carry);
    if (s1_advance) begin
      out_valid_d = 1'b1;
      out_sum_d   = s1_hi << s1_q.keff;
      out_exact_d = {1'b0, s1_q.a} + {1'b0, s1_q.b};
      out_err_d   = (CARRY_EN != 0) ? (s1_q.lo & s1_mask) : s1_q.lo;
    end else if (out_accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_exact_q <= '0;
      out_err_q   <= '0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_exact_q <= out_exact_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_exact = out_exact_q;
  assign out_err   = out_err_q;

  approx_err_stats #(
    .ERR_W (MAX_K + 1),
    .CNT_W (CNT_W),
    .ACC_W (ACC_W)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs          (out_accept),
    .err         (out_err_q),
    .clear_stats (clear_stats),
    .err_count   (err_count),
    .err_max     (err_max),
    .err_acc     (err_acc)
  );

endmodule

// File: doc/approx_adder_pipe.md
Name: approx_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 8-bit truncated adders: WIDTH-bit unsigned add, with the number of zeroed result LSBs selected per transaction.
- Computes the exact sum and the absolute error alongside the approximate result.
- Keeps running error statistics (erroneous-result count, maximum error, accumulated error) so ErrorEval benches measure error metrics in-line instead of post-processing.
- Sits between a stimulus source and a scoreboard, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits (>=2).
- MAX_K, 4, maximum number of truncated LSBs (1..WIDTH-1).
- CARRY_EN, 0, 0 = carry out of the truncated low part is discarded; 1 = that carry is forwarded into the upper part.
- CNT_W, 16, width of the erroneous-result counter.
- ACC_W, 32, width of the accumulated-error register.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block can accept a transaction.
- in_a  in  WIDTH  operand A, unsigned.
- in_b  in  WIDTH  operand B, unsigned.
- in_k  in  $clog2(MAX_K+1)  truncated-LSB count for this transaction.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH+1  approximate sum.
- out_exact  out  WIDTH+1  exact sum a+b.
- out_err  out  MAX_K+1  out_exact - out_sum (never negative).
- clear_stats  in  1  synchronous clear of all statistics.
- err_count  out  CNT_W  number of accepted results with out_err != 0.
- err_max  out  MAX_K+1  largest out_err seen.
- err_acc  out  ACC_W  sum of out_err over accepted results.

Behaviour:
- Reset: all pipeline valids, out_* data and statistics go to 0; in_ready is 1 one cycle after rst_n deasserts.
- Reset mid-operation drops in-flight transactions silently.
- Accepted-handshake definitions:
  - Input accepted when in_valid & in_ready.
  - Output accepted when out_valid & out_ready.
- Effective k: keff = min(in_k, MAX_K). Values above MAX_K clamp and are not errors.
- Arithmetic:
  - lo = a[keff-1:0] + b[keff-1:0], width keff+1.
  - hi = a[W-1:keff] + b[W-1:keff] + (CARRY_EN ? lo[keff] : 0).
  - out_sum = {hi, keff zeros}.
  - out_exact = a+b.
  - out_err = CARRY_EN ? lo[keff-1:0] : lo.
  - keff=0 gives out_sum = out_exact and out_err = 0.
- Pipeline: 2 registered stages.
  - S1 captures operands, keff and lo.
  - S2 computes hi, out_sum, out_exact and out_err, and holds the output registers.
  - Latency is 2 cycles from input acceptance to out_valid with no stall.
  - Throughput is 1 per cycle.
- Backpressure:
  - S2 holds its data while out_valid & !out_ready.
  - S1 advances only when S2 is empty or draining.
  - in_ready = !s1_valid | s1_advance, combinational from out_ready; no bubble when streaming.
- Output stability: out_* data and out_valid must not change while out_valid & !out_ready.
- Statistics update only on an output-accepted cycle:
  - err_count += (out_err != 0), saturating at all-ones.
  - err_acc += out_err, saturating at all-ones.
  - err_max = max(err_max, out_err).
- clear_stats: zeroes statistics next edge and has priority over a simultaneous update; the transaction in that cycle is not counted. Pipeline contents are unaffected.
- Statistics are registered and visible the cycle after the handshake.

Decomposition:
- Package approx_adder_pkg holds:
  - Function clamp_k.
  - localparam KW = $clog2(MAX_K+1).
  - A struct typedef for the S1 payload (a, b, keff, lo).
- One natural sub-module: approx_err_stats. It takes the handshake strobe, out_err and clear_stats, and outputs the three statistics with saturation.

Test Plan:
- W=8, MAX_K=4, CARRY_EN=0; a=0x0F, b=0x01, k=4 -> out_exact=0x010, out_sum=0x000, out_err=16; err_count=1, err_max=16, err_acc=16.
- Same configuration with CARRY_EN=1, same stimulus -> out_sum=0x010, out_err=0, err_count unchanged.
- k=0 and k=7 (clamped to 4); a=0xFF, b=0xFF -> k=0: out_sum=out_exact=0x1FE, out_err=0. k=7: out_sum=0x1E0 (CARRY_EN=0), out_err=30.
- Stream 100 back-to-back transactions with out_ready toggled pseudo-randomly -> results in order with no loss or duplication; outputs held stable while stalled; in_ready never high while the pipeline is full and stalled.
- CNT_W=4; 20 erroneous transactions -> err_count saturates at 15; clear_stats asserted together with a handshake -> all statistics 0 next cycle.
- rst_n pulsed low asynchronously mid-stream with 2 transactions in flight -> out_valid=0 and statistics 0 immediately; first new transaction after reset emerges with 2-cycle latency.
